// File: rtl/pe_cluster_feeder.sv
// Sequencer feeding one PE cluster per job: weight stream, activation stream,
// start pulse, wait for compute completion, then hand the psum vector downstream.
module pe_cluster_feeder #(
    parameter int DATA_BITWIDTH = 16,
    parameter int X_dim         = 3,
    parameter int W_COUNT       = 9,
    parameter int A_COUNT       = 15
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic [DATA_BITWIDTH*X_dim-1:0] cmd_bias,
    input  logic [DATA_BITWIDTH-1:0]       data_in,
    input  logic                           data_valid,
    output logic                           data_ready,
    output logic [DATA_BITWIDTH-1:0]       filt_in,
    output logic [DATA_BITWIDTH-1:0]       act_in,
    output logic                           load_en_wght,
    output logic                           load_en_act,
    output logic                           start,
    output logic [DATA_BITWIDTH*X_dim-1:0] pe_before,
    input  logic                           load_done,
    input  logic                           compute_done,
    input  logic [DATA_BITWIDTH*X_dim-1:0] pe_out,
    output logic [DATA_BITWIDTH*X_dim-1:0] res_data,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic                           busy
);
    localparam int MAX_COUNT = (W_COUNT > A_COUNT) ? W_COUNT : A_COUNT;
    localparam int CW        = $clog2(MAX_COUNT + 1);
    localparam logic [CW-1:0] W_LAST = CW'(W_COUNT - 1);
    localparam logic [CW-1:0] A_LAST = CW'(A_COUNT - 1);

    typedef enum logic [2:0] {
        IDLE, LOAD_W, LOAD_A, WAIT_LOAD, START, COMPUTE, SETTLE, OUT
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt;
    logic          done_q;
    logic          cmd_fire, data_fire, res_fire, done_rise, last_word;
    logic          cmd_ready_d, data_ready_d, start_d, res_valid_d, busy_d;

    // The registered handshake flags mirror the state, so they qualify transfers directly.
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign data_fire = data_valid && data_ready;
    assign res_fire  = res_valid && res_ready;
    assign done_rise = compute_done && !done_q;
    assign last_word = (state == LOAD_W) ? (cnt == W_LAST) : (cnt == A_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        // NOTE: default assignment first so every path drives state_next and no latch is inferred.
        state_next = state;
        case (state)
            IDLE:      if (cmd_fire)               state_next = LOAD_W;
            LOAD_W:    if (data_fire && last_word) state_next = LOAD_A;
            LOAD_A:    if (data_fire && last_word) state_next = WAIT_LOAD;
            WAIT_LOAD: if (load_done)              state_next = START;
            START:                                 state_next = COMPUTE;
            COMPUTE:   if (done_rise)              state_next = SETTLE;
            SETTLE:                                state_next = OUT;
            OUT:       if (res_fire)               state_next = IDLE;
            default:                               state_next = IDLE;
        endcase
    end

    // Control outputs are decoded from the next state and registered below.
    always_comb begin
        cmd_ready_d  = (state_next == IDLE);
        data_ready_d = (state_next == LOAD_W) || (state_next == LOAD_A);
        start_d      = (state_next == START);
        res_valid_d  = (state_next == OUT);
        busy_d       = (state_next != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmd_ready    <= 1'b0;
            data_ready   <= 1'b0;
            start        <= 1'b0;
            res_valid    <= 1'b0;
            busy         <= 1'b0;
            load_en_wght <= 1'b0;
            load_en_act  <= 1'b0;
            filt_in      <= '0;
            act_in       <= '0;
            pe_before    <= '0;
            res_data     <= '0;
            cnt          <= '0;
            done_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
            cmd_ready    <= cmd_ready_d;
            data_ready   <= data_ready_d;
            start        <= start_d;
            res_valid    <= res_valid_d;
            busy         <= busy_d;
            done_q       <= compute_done;
            load_en_wght <= 1'b0;
            load_en_act  <= 1'b0;
            if (cmd_fire) begin
                pe_before <= cmd_bias;
                cnt       <= '0;
            end
            if (data_fire) begin
                if (state == LOAD_W) begin
                    filt_in      <= data_in;
                    load_en_wght <= 1'b1;
                end else begin
                    act_in      <= data_in;
                    load_en_act <= 1'b1;
                end
                cnt <= last_word ? '0 : cnt + 1'b1;
            end
            // The cluster's psum register is valid one cycle after its done edge.
            if (state == SETTLE) res_data <= pe_out;
        end
    end
endmodule

// File: tb/tb_pe_cluster_feeder.sv
// Self-checking bench for pe_cluster_feeder; the bench plays the PE cluster,
// the data source and the result sink, and compares against expected streams.
module tb_pe_cluster_feeder;
    localparam int DW = 16;
    localparam int XD = 3;
    localparam int WC = 9;
    localparam int AC = 15;
    localparam int VW = DW * XD;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid, cmd_ready;
    logic [VW-1:0] cmd_bias;
    logic [DW-1:0] data_in;
    logic          data_valid, data_ready;
    logic [DW-1:0] filt_in, act_in;
    logic          load_en_wght, load_en_act, start;
    logic [VW-1:0] pe_before;
    logic          load_done, compute_done;
    logic [VW-1:0] pe_out;
    logic [VW-1:0] res_data;
    logic          res_valid, res_ready, busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cnt = 0;
    logic [DW-1:0] got_w[$];
    logic [DW-1:0] got_a[$];
    logic [DW-1:0] w_words[WC];
    logic [DW-1:0] a_words[AC];

    pe_cluster_feeder #(
        .DATA_BITWIDTH(DW), .X_dim(XD), .W_COUNT(WC), .A_COUNT(AC)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_bias(cmd_bias),
        .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready),
        .filt_in(filt_in), .act_in(act_in),
        .load_en_wght(load_en_wght), .load_en_act(load_en_act),
        .start(start), .pe_before(pe_before),
        .load_done(load_done), .compute_done(compute_done), .pe_out(pe_out),
        .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // What the cluster actually saw on its load ports and start input.
    always @(negedge clk) begin
        if (load_en_wght) got_w.push_back(filt_in);
        if (load_en_act)  got_a.push_back(act_in);
        if (start)        start_cnt <= start_cnt + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, 64'({cmd_ready, data_ready, load_en_wght, load_en_act,
                                   start, res_valid, busy}), 64'd0);
        check({tag, "_words"}, 64'({filt_in, act_in}), 64'd0);
        check({tag, "_pe_before"}, 64'(pe_before), 64'd0);
        check({tag, "_res_data"}, 64'(res_data), 64'd0);
    endtask

    task automatic fill_words(input bit ramp);
        for (int i = 0; i < WC; i++) w_words[i] = ramp ? DW'(i + 1)  : DW'($urandom);
        for (int i = 0; i < AC; i++) a_words[i] = ramp ? DW'(i + 10) : DW'($urandom);
    endtask

    // stall: 0 continuous, 1 every other cycle, 2 random gaps.
    // c_lat: cycles between the end of the start pulse and the compute_done edge.
    // abort_at: stream index at which reset is asserted mid-cycle (-1 = none).
    task automatic run_job(input logic [VW-1:0] bias, input int stall, input int ld_delay,
                           input int c_lat, input bit stale, input int bp,
                           input logic [VW-1:0] pe_val, input int abort_at, input bit check_lat);
        logic [DW-1:0] stream[$];
        int idx, guard, k0, k1, tstart, tld, start_base;
        bit rdy, v, seen;
        logic [VW-1:0] held;

        stream.delete();
        for (int i = 0; i < WC; i++) stream.push_back(w_words[i]);
        for (int i = 0; i < AC; i++) stream.push_back(a_words[i]);
        got_w.delete();
        got_a.delete();
        start_base = start_cnt;
        k0 = 0;

        cmd_bias  = bias;
        cmd_valid = 1'b1;
        guard = 0;
        forever begin
            rdy = cmd_ready;
            k0  = cyc;
            step();
            guard++;
            if (rdy || guard > 50) break;
        end
        cmd_valid = 1'b0;
        cmd_bias  = VW'({$urandom, $urandom});
        check("cmd_accept", 64'(rdy), 64'd1);
        check("pe_before_latched", 64'(pe_before), 64'(bias));
        check("busy_after_accept", 64'({busy, cmd_ready}), 64'b10);

        idx = 0;
        guard = 0;
        while (idx < stream.size() && guard < 1000) begin
            case (stall)
                0:       v = 1'b1;
                1:       v = (guard % 2 == 0);
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            data_valid = v;
            data_in    = v ? stream[idx] : DW'($urandom);
            rdy        = data_ready;
            if (abort_at >= 0 && idx == abort_at) begin
                #2 reset = 1'b0;
                #1 check_all_zero("midjob_reset");
                data_valid = 1'b0;
                step();
                step();
                reset = 1'b1;
                step();
                check("cmd_ready_after_midjob_reset", 64'({cmd_ready, busy}), 64'b10);
                return;
            end
            step();
            guard++;
            if (v && rdy) idx++;
        end
        check("stream_consumed", 64'(idx), 64'(stream.size()));
        check("data_ready_low_after_stream", 64'(data_ready), 64'd0);

        if (stale) begin
            compute_done = 1'b1;
            pe_out = VW'({$urandom, $urandom});
        end
        data_valid = 1'b1;
        data_in    = DW'($urandom);
        for (int i = 0; i < ld_delay; i++) begin
            check("no_start_before_load_done", 64'({start, busy}), 64'b01);
            step();
        end
        load_done = 1'b1;
        tld = cyc;
        seen = 1'b0;
        tstart = 0;
        for (int i = 0; i < 10; i++) begin
            if (start) begin
                seen = 1'b1;
                tstart = cyc;
                break;
            end
            step();
        end
        check("start_seen", 64'(seen), 64'd1);
        check("start_after_load_done", 64'(tstart - tld), 64'd1);
        load_done  = 1'b0;
        data_valid = 1'b0;
        step();
        check("start_single_cycle", 64'(start), 64'd0);

        if (stale) begin
            for (int i = 0; i < 6; i++) begin
                check("stale_done_ignored", 64'({res_valid, busy}), 64'b01);
                step();
            end
            compute_done = 1'b0;
            step();
            step();
        end else begin
            for (int i = 0; i < c_lat; i++) begin
                pe_out = VW'({$urandom, $urandom});
                step();
            end
        end
        compute_done = 1'b1;
        pe_out = pe_val;

        seen = 1'b0;
        k1 = 0;
        for (int i = 0; i < 20; i++) begin
            if (res_valid) begin
                seen = 1'b1;
                k1 = cyc;
                break;
            end
            step();
        end
        check("res_valid_seen", 64'(seen), 64'd1);
        check("res_data", 64'(res_data), 64'(pe_val));
        check("cmd_ready_low_in_out", 64'(cmd_ready), 64'd0);
        if (check_lat) check("job_latency", 64'(k1 - k0), 64'(WC + AC + c_lat + 5));
        compute_done = 1'b0;
        pe_out = VW'({$urandom, $urandom});

        held = res_data;
        res_ready = 1'b0;
        cmd_valid = (bp > 0);
        for (int i = 0; i < bp; i++) begin
            cmd_bias = VW'({$urandom, $urandom});
            step();
            check("bp_res_valid", 64'(res_valid), 64'd1);
            check("bp_res_data", 64'(res_data), 64'(held));
            check("bp_cmd_ready", 64'(cmd_ready), 64'd0);
            check("bp_pe_before", 64'(pe_before), 64'(bias));
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("handshake_to_idle", 64'({res_valid, cmd_ready, busy}), 64'b010);

        check("w_pulse_count", 64'(got_w.size()), 64'(WC));
        for (int i = 0; i < WC; i++)
            check("w_word", (i < got_w.size()) ? 64'(got_w[i]) : 64'hdead_beef_dead_beef,
                  64'(w_words[i]));
        check("a_pulse_count", 64'(got_a.size()), 64'(AC));
        for (int i = 0; i < AC; i++)
            check("a_word", (i < got_a.size()) ? 64'(got_a[i]) : 64'hdead_beef_dead_beef,
                  64'(a_words[i]));
        check("start_pulse_count", 64'(start_cnt - start_base), 64'd1);
    endtask

    initial begin
        reset        = 1'b0;
        cmd_valid    = 1'b0;
        cmd_bias     = '0;
        data_in      = '0;
        data_valid   = 1'b0;
        load_done    = 1'b0;
        compute_done = 1'b0;
        pe_out       = '0;
        res_ready    = 1'b0;

        // Reset held with random inputs: every output stays at zero.
        for (int i = 0; i < 4; i++) begin
            cmd_valid    = 1'($urandom_range(0, 1));
            cmd_bias     = VW'({$urandom, $urandom});
            data_in      = DW'($urandom);
            data_valid   = 1'($urandom_range(0, 1));
            load_done    = 1'($urandom_range(0, 1));
            compute_done = 1'($urandom_range(0, 1));
            pe_out       = VW'({$urandom, $urandom});
            res_ready    = 1'($urandom_range(0, 1));
            step();
            check_all_zero("in_reset");
        end
        cmd_valid    = 1'b0;
        data_valid   = 1'b0;
        load_done    = 1'b0;
        compute_done = 1'b0;
        res_ready    = 1'b0;
        reset        = 1'b1;
        step();
        check("cmd_ready_after_release", 64'({cmd_ready, busy, data_ready}), 64'b100);

        // Nominal job, continuous stream, immediate load_done.
        fill_words(1'b1);
        run_job({16'd3, 16'd2, 16'd1}, 0, 0, 3, 1'b0, 0,
                {16'd30, 16'd20, 16'd10}, -1, 1'b1);

        // Stream stalled every other cycle, delayed load_done.
        fill_words(1'b0);
        run_job(VW'({$urandom, $urandom}), 1, 3, 2, 1'b0, 0,
                VW'({$urandom, $urandom}), -1, 1'b0);

        // compute_done already high across START.
        fill_words(1'b0);
        run_job(VW'({$urandom, $urandom}), 0, 0, 0, 1'b1, 0,
                VW'({$urandom, $urandom}), -1, 1'b0);

        // Result held under 20 cycles of backpressure.
        fill_words(1'b0);
        run_job(VW'({$urandom, $urandom}), 2, 1, 4, 1'b0, 20,
                VW'({$urandom, $urandom}), -1, 1'b0);

        // Reset during the 7th activation word, then a complete job from scratch.
        fill_words(1'b0);
        run_job(VW'({$urandom, $urandom}), 0, 0, 1, 1'b0, 0,
                VW'({$urandom, $urandom}), WC + 6, 1'b0);
        fill_words(1'b1);
        run_job({16'd7, 16'd8, 16'd9}, 0, 0, 5, 1'b0, 0,
                {16'd70, 16'd80, 16'd90}, -1, 1'b1);

        // Randomized jobs.
        for (int j = 0; j < 3; j++) begin
            fill_words(1'b0);
            run_job(VW'({$urandom, $urandom}), 2, int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 5)), VW'({$urandom, $urandom}), -1, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pe_cluster_feeder.md
# pe_cluster_feeder

Initiator-side sequencer that drives one PE cluster through a complete job: it streams weights, then activations, from the global-buffer side into the cluster's load ports. It then pulses `start`, waits for completion, and captures the cluster's registered partial-sum vector. Finally it presents that vector downstream with a valid/ready handshake. It sits between the global buffer / router and the PE cluster and owns the cluster's `act_in`, `filt_in`, `load_en_*`, `start` and `pe_before` inputs.

## Interface
- `DATA_BITWIDTH`, 16, width of one weight/activation/psum word
- `X_dim`, 3, number of psum lanes in the cluster output vector
- `W_COUNT`, 9, weight words per job (kernel_size*Y_dim); must be ≥1
- `A_COUNT`, 15, activation words per job (act_size*Y_dim); must be ≥1
- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted)
- `cmd_valid`  in  1  job request
- `cmd_ready`  out  1  feeder idle, accepts job
- `cmd_bias`  in  DATA_BITWIDTH*X_dim  incoming psum vector for the job; latched on command accept
- `data_in`  in  DATA_BITWIDTH  weight then activation stream
- `data_valid`  in  1  `data_in` valid
- `data_ready`  out  1  feeder accepts `data_in`
- `filt_in`  out  DATA_BITWIDTH  to cluster
- `act_in`  out  DATA_BITWIDTH  to cluster
- `load_en_wght`  out  1  to cluster, one cycle per weight word
- `load_en_act`  out  1  to cluster, one cycle per activation word
- `start`  out  1  to cluster, single-cycle pulse
- `pe_before`  out  DATA_BITWIDTH*X_dim  to cluster, equals latched bias
- `load_done`  in  1  from cluster
- `compute_done`  in  1  from cluster
- `pe_out`  in  DATA_BITWIDTH*X_dim  from cluster (registered there)
- `res_data`  out  DATA_BITWIDTH*X_dim  captured psum vector
- `res_valid`  out  1  result available
- `res_ready`  in  1  downstream accepts result
- `busy`  out  1  high in every state except IDLE

## Operation
- The FSM has eight states: IDLE, LOAD_W, LOAD_A, WAIT_LOAD, START, COMPUTE, SETTLE, OUT.
- IDLE: `cmd_ready`=1. On `cmd_valid`, latch `cmd_bias` into `pe_before`, clear the word counter, and go to LOAD_W.
- LOAD_W: `data_ready`=1. Each accepted word (`data_valid`&&`data_ready`) registers to `filt_in` with `load_en_wght`=1 in the next cycle. The counter increments per accept. On the W_COUNT-th accept, clear the counter and go to LOAD_A.
- LOAD_A: same as LOAD_W, using `act_in`/`load_en_act` and A_COUNT. On the last accept, go to WAIT_LOAD.
- Stalls: when `data_valid`=0, the load enable is 0 in the following cycle. `filt_in`/`act_in` hold their last value. Gaps of any length are legal.
- WAIT_LOAD: `data_ready`=0. Exit to START when `load_done` is 1. The level is sampled starting with the first cycle in this state.
- START: `start`=1 for exactly this cycle. Next state is COMPUTE.
- COMPUTE: exit to SETTLE on a rising edge of `compute_done` (0 in the previous cycle, 1 now). A `compute_done` that is already high from a prior job is ignored until it drops.
- SETTLE: one cycle, absorbing the cluster's output register. At the end of this cycle, capture `pe_out` into `res_data` and go to OUT.
- OUT: `res_valid`=1 and `res_data` stable until `res_ready`. On handshake go to IDLE. `res_valid` and `cmd_ready` are never high together.
- Arithmetic: none. Words pass through unmodified. Counter width is clog2(max(W_COUNT,A_COUNT)+1).

## Timing
- All outputs are registered.
- Reset values: `cmd_ready`=0 during reset and 1 in the first cycle after release. All other outputs are 0. State is IDLE.
- Reset is asynchronous: asserting it mid-job forces IDLE immediately, clears all outputs including `pe_before` and `res_data`, and discards any partial load.
- Word accepted in cycle t appears on `filt_in`/`act_in` with its enable in cycle t+1.
- Minimum job latency from command accept to `res_valid`, with a continuous stream, load_done immediate and compute latency C: W_COUNT+A_COUNT+C+5 cycles.
- A `cmd_valid` arriving in any state other than IDLE is not accepted; it must be held by the source.
- `data_valid` outside LOAD_W/LOAD_A has no effect, because `data_ready`=0.

## Test plan
- Reset: hold `reset`=0 with random inputs. All outputs must be 0. Release, and `cmd_ready`=1 on the next cycle.
- Nominal job: bias {3,2,1}, weights 1..9, acts 10..24 continuous. The bench checks three things:
  - exactly 9 `load_en_wght` pulses carrying 1..9, then 15 `load_en_act` pulses carrying 10..24;
  - one `start` pulse after `load_done`;
  - on a `compute_done` edge with model `pe_out`={30,20,10}, `res_data`={30,20,10}.
- Stalled stream: deassert `data_valid` every other cycle. Enable pulses must be gapped to match, with no word lost or duplicated. The counter reaches 9/15 exactly.
- Stale done: `compute_done` held 1 across START. The FSM must stay in COMPUTE until `compute_done` falls and rises again.
- Backpressure: `res_ready`=0 for 20 cycles. `res_valid` and `res_data` are held, `cmd_ready`=0 throughout, and the FSM goes to IDLE one cycle after `res_ready`=1.
- Mid-job reset: assert `reset` during LOAD_A word 7. Outputs go to 0 immediately. The next job loads all 9+15 words from scratch.
